// File: rtl/plc_input_image.sv
// Input-scan stage: synchronises and debounces eight field-input bytes and freezes
// a process-input image on request. Optional forcing via `INPUT_FORCE_EN.
module plc_input_image #(
  parameter int unsigned PRESC   = 4,
  parameter int unsigned DEB_CNT = 3,
  parameter int unsigned CNT_W   = 4
) (
  input  logic       zegar,
  input  logic       reset,
  input  logic [7:0] raw0,
  input  logic [7:0] raw1,
  input  logic [7:0] raw2,
  input  logic [7:0] raw3,
  input  logic [7:0] raw4,
  input  logic [7:0] raw5,
  input  logic [7:0] raw6,
  input  logic [7:0] raw7,
  input  logic       scan_req,
`ifdef INPUT_FORCE_EN
  input  logic       force_we,
  input  logic [2:0] force_sel,
  input  logic [7:0] force_mask,
  input  logic [7:0] force_val,
`endif
  output logic       scan_ack,
  output logic [7:0] I0,
  output logic [7:0] I1,
  output logic [7:0] I2,
  output logic [7:0] I3,
  output logic [7:0] I4,
  output logic [7:0] I5,
  output logic [7:0] I6,
  output logic [7:0] I7,
  output logic       image_changed,
  output logic       deb_busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACK,
    ST_HOLD
  } state_e;

  localparam int unsigned PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESC - 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEB_CNT - 1);

  logic [7:0][7:0] raw_a;

  logic [7:0][7:0]       sync1_q, sync1_d;
  logic [7:0][7:0]       sync2_q, sync2_d;
  logic [7:0][7:0]       cand_q,  cand_d;
  logic [7:0][7:0]       deb_q,   deb_d;
  logic [7:0][CNT_W-1:0] cnt_q,   cnt_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [7:0][7:0]       img_q,   img_d;
  logic                  scan_ack_q, scan_ack_d;
  logic                  image_changed_q, image_changed_d;
  state_e                state_q, state_d;

  logic            tick;
  logic [7:0][7:0] new_img;

  assign raw_a = {raw7, raw6, raw5, raw4, raw3, raw2, raw1, raw0};

  // Two-flop synchroniser per byte
  always_comb begin
    sync1_d = raw_a;
    sync2_d = sync1_q;
  end

  // Free-running prescaler; with PRESC=1 the counter stays at 0 and tick is constant
  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  always_comb begin
    cand_d   = cand_q;
    deb_d    = deb_q;
    cnt_d    = cnt_q;
    deb_busy = 1'b0;
    for (int unsigned n = 0; n < 8; n++) begin
      deb_busy = deb_busy | (cand_q[n] != deb_q[n]);
      if (tick) begin
        if (sync2_q[n] != cand_q[n]) begin
          cand_d[n] = sync2_q[n];
          cnt_d[n]  = '0;
        end else if (cand_q[n] != deb_q[n]) begin
          if (cnt_q[n] == CNT_LAST) begin
            deb_d[n] = cand_q[n];
            cnt_d[n] = '0;
          end else begin
            cnt_d[n] = cnt_q[n] + 1'b1;
          end
        end else begin
          cnt_d[n] = '0;
        end
      end
    end
  end

`ifdef INPUT_FORCE_EN
  logic [7:0][7:0] mask_q, mask_d;
  logic [7:0][7:0] val_q,  val_d;

  always_comb begin
    mask_d = mask_q;
    val_d  = val_q;
    if (force_we) begin
      mask_d[force_sel] = force_mask;
      val_d[force_sel]  = force_val;
    end
    for (int unsigned n = 0; n < 8; n++) begin
      new_img[n] = (deb_q[n] & ~mask_q[n]) | (val_q[n] & mask_q[n]);
    end
  end

  always_ff @(posedge zegar) begin
    if (reset) begin
      mask_q <= '0;
      val_q  <= '0;
    end else begin
      mask_q <= mask_d;
      val_q  <= val_d;
    end
  end
`else
  always_comb begin
    new_img = deb_q;
  end
`endif

  // Latch uses pre-edge deb, so a same-edge debounce update shows at the next scan
  always_comb begin
    state_d         = state_q;
    img_d           = img_q;
    scan_ack_d      = 1'b0;
    image_changed_d = image_changed_q;
    unique case (state_q)
      ST_IDLE: begin
        if (scan_req) begin
          img_d           = new_img;
          image_changed_d = (new_img != img_q);
          scan_ack_d      = 1'b1;
          state_d         = ST_ACK;
        end
      end
      ST_ACK: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!scan_req) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge zegar) begin
    if (reset) begin
      sync1_q         <= '0;
      sync2_q         <= '0;
      cand_q          <= '0;
      deb_q           <= '0;
      cnt_q           <= '0;
      presc_q         <= '0;
      img_q           <= '0;
      scan_ack_q      <= 1'b0;
      image_changed_q <= 1'b0;
      state_q         <= ST_IDLE;
    end else begin
      sync1_q         <= sync1_d;
      sync2_q         <= sync2_d;
      cand_q          <= cand_d;
      deb_q           <= deb_d;
      cnt_q           <= cnt_d;
      presc_q         <= presc_d;
      img_q           <= img_d;
      scan_ack_q      <= scan_ack_d;
      image_changed_q <= image_changed_d;
      state_q         <= state_d;
    end
  end

  assign scan_ack      = scan_ack_q;
  assign image_changed = image_changed_q;
  assign I0 = img_q[0];
  assign I1 = img_q[1];
  assign I2 = img_q[2];
  assign I3 = img_q[3];
  assign I4 = img_q[4];
  assign I5 = img_q[5];
  assign I6 = img_q[6];
  assign I7 = img_q[7];

endmodule

// File: tb/tb_plc_input_image.sv
// Directed bench for plc_input_image: table of scan vectors plus hand-written
// sequences for debounce timing, bounce, same-edge latch and reset mid-scan.
module tb_plc_input_image;

  localparam int unsigned TB_PRESC   = 4;
  localparam int unsigned TB_DEB_CNT = 3;

  logic       zegar = 1'b0;
  logic       reset;
  logic [7:0] raw0, raw1, raw2, raw3, raw4, raw5, raw6, raw7;
  logic       scan_req;
  logic       scan_ack;
  logic [7:0] I0, I1, I2, I3, I4, I5, I6, I7;
  logic       image_changed;
  logic       deb_busy;
`ifdef INPUT_FORCE_EN
  logic       force_we;
  logic [2:0] force_sel;
  logic [7:0] force_mask;
  logic [7:0] force_val;
`endif

  logic [63:0] img;
  assign img = {I7, I6, I5, I4, I3, I2, I1, I0};

  int n_tests = 0;
  int n_fail  = 0;

  always #5 zegar = ~zegar;

  plc_input_image #(
    .PRESC  (TB_PRESC),
    .DEB_CNT(TB_DEB_CNT),
    .CNT_W  (4)
  ) dut (
    .zegar        (zegar),
    .reset        (reset),
    .raw0         (raw0),
    .raw1         (raw1),
    .raw2         (raw2),
    .raw3         (raw3),
    .raw4         (raw4),
    .raw5         (raw5),
    .raw6         (raw6),
    .raw7         (raw7),
    .scan_req     (scan_req),
`ifdef INPUT_FORCE_EN
    .force_we     (force_we),
    .force_sel    (force_sel),
    .force_mask   (force_mask),
    .force_val    (force_val),
`endif
    .scan_ack     (scan_ack),
    .I0           (I0),
    .I1           (I1),
    .I2           (I2),
    .I3           (I3),
    .I4           (I4),
    .I5           (I5),
    .I6           (I6),
    .I7           (I7),
    .image_changed(image_changed),
    .deb_busy     (deb_busy)
  );

  typedef struct {
    logic [63:0] raw;
    int          settle;
    int          hold;
    logic [63:0] exp_img;
    logic        exp_chg;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_raw(input logic [63:0] r);
    {raw7, raw6, raw5, raw4, raw3, raw2, raw1, raw0} = r;
  endtask

  task automatic do_scan(input int hold, input logic [63:0] exp_img,
                         input logic exp_chg, input string tag);
    int extra;
    extra = 0;
    @(negedge zegar);
    scan_req = 1'b1;
    @(posedge zegar);
    #1;
    chk({tag, "_ack"}, 64'(scan_ack), 64'h1);
    chk({tag, "_img"}, img, exp_img);
    chk({tag, "_chg"}, 64'(image_changed), 64'(exp_chg));
    for (int c = 1; c < hold; c++) begin
      @(posedge zegar);
      #1;
      if (scan_ack) extra++;
    end
    @(negedge zegar);
    scan_req = 1'b0;
    repeat (2) begin
      @(posedge zegar);
      #1;
      if (scan_ack) extra++;
    end
    chk({tag, "_ack_once"}, 64'(extra), 64'h0);
    chk({tag, "_held"}, img, exp_img);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt_rise;
    int hi;

    vecs[0] = '{64'h8877665544332211, 30, 2,  64'h8877665544332211, 1'b1};
    vecs[1] = '{64'h8877665544332211, 5,  10, 64'h8877665544332211, 1'b0};
    vecs[2] = '{64'h00FF00FF00FF00FF, 0,  2,  64'h8877665544332211, 1'b0};
    vecs[3] = '{64'h00FF00FF00FF00FF, 30, 2,  64'h00FF00FF00FF00FF, 1'b1};
    vecs[4] = '{64'h80FF00FF00FF00FF, 30, 3,  64'h80FF00FF00FF00FF, 1'b1};

    reset    = 1'b1;
    scan_req = 1'b0;
    set_raw(64'h0);
    raw0     = 8'hFF;
`ifdef INPUT_FORCE_EN
    force_we   = 1'b0;
    force_sel  = '0;
    force_mask = '0;
    force_val  = '0;
`endif

    // Reset state
    repeat (2) @(posedge zegar);
    #1;
    chk("rst_img", img, 64'h0);
    chk("rst_ack", 64'(scan_ack), 64'h0);
    chk("rst_chg", 64'(image_changed), 64'h0);
    chk("rst_busy", 64'(deb_busy), 64'h0);
    @(negedge zegar);
    raw0  = 8'h00;
    reset = 1'b0;
    repeat (3) @(posedge zegar);

    // Debounce timing on byte 3
    @(negedge zegar);
    raw3 = 8'hA5;
    cnt_rise = 0;
    do begin
      @(posedge zegar);
      #1;
      cnt_rise++;
    end while (!deb_busy && cnt_rise <= 50);
    chk("busy_rise_window", 64'(cnt_rise >= 3 && cnt_rise <= int'(TB_PRESC) + 2), 64'h1);
    hi = 1;
    forever begin
      @(posedge zegar);
      #1;
      if (!deb_busy || hi > 100) break;
      hi++;
    end
    chk("busy_len", 64'(hi), 64'(TB_DEB_CNT * TB_PRESC));
    chk("i3_frozen", 64'(I3), 64'h00);
    do_scan(2, 64'h00000000_A5000000, 1'b1, "deb3");

    // Latch on the same edge as a debounce update takes the old value
    @(negedge zegar);
    raw3 = 8'h5A;
    cnt_rise = 0;
    do begin
      @(posedge zegar);
      #1;
      cnt_rise++;
    end while (!deb_busy && cnt_rise <= 50);
    chk("busy_rise2", 64'(deb_busy), 64'h1);
    for (int k = 1; k < int'(TB_DEB_CNT * TB_PRESC); k++) begin
      @(posedge zegar);
      #1;
    end
    do_scan(2, 64'h00000000_A5000000, 1'b0, "same_edge");
    do_scan(2, 64'h00000000_5A000000, 1'b1, "after_edge");

    // Bounce on byte 1: toggling every 3 cycles never debounces
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          @(negedge zegar);
          if (i % 3 == 0) raw1 = raw1 ^ 8'h0F;
        end
      end
      begin
        repeat (20) @(posedge zegar);
        do_scan(2, 64'h00000000_5A000000, 1'b0, "bounce_mid");
      end
    join
    @(negedge zegar);
    raw1 = 8'h0F;
    do_scan(2, 64'h00000000_5A000000, 1'b0, "bounce_end");
    repeat (30) @(posedge zegar);
    do_scan(2, 64'h00000000_5A000F00, 1'b1, "bounce_settled");

    // Vector table
    for (int i = 0; i < 5; i++) begin
      @(negedge zegar);
      set_raw(vecs[i].raw);
      repeat (vecs[i].settle) @(posedge zegar);
      do_scan(vecs[i].hold, vecs[i].exp_img, vecs[i].exp_chg, $sformatf("vec%0d", i));
    end

    // Reset on the edge where scan_req rises
    @(negedge zegar);
    scan_req = 1'b1;
    reset    = 1'b1;
    @(posedge zegar);
    #1;
    chk("rmid_ack", 64'(scan_ack), 64'h0);
    chk("rmid_img", img, 64'h0);
    chk("rmid_chg", 64'(image_changed), 64'h0);
    chk("rmid_busy", 64'(deb_busy), 64'h0);
    @(negedge zegar);
    reset    = 1'b0;
    scan_req = 1'b0;
    repeat (30) @(posedge zegar);
    do_scan(2, 64'h80FF00FF00FF00FF, 1'b1, "post_reset");

`ifdef INPUT_FORCE_EN
    @(negedge zegar);
    force_we   = 1'b1;
    force_sel  = 3'd5;
    force_mask = 8'hF0;
    force_val  = 8'hA0;
    @(negedge zegar);
    force_we = 1'b0;
    raw5     = 8'h0C;
    repeat (30) @(posedge zegar);
    do_scan(2, 64'h80FFACFF00FF00FF, 1'b1, "force5");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/plc_input_image.md
Name: plc_input_image

Overview:
- Input-scan stage that sits directly upstream of the PLC processor and drives its I0..I7 byte inputs.
- Synchronises and debounces eight raw 8-bit field-input bytes.
- On a request from the processor at the start of a PLC cycle, freezes a consistent process-input image.
- The frozen image is held constant on I0..I7 for the whole program cycle.

Parameters:
- PRESC, 4: sample-tick period in zegar cycles (>=1); debounce counters advance only on ticks.
- DEB_CNT, 3: number of consecutive stable ticks required before a debounced byte changes (>=1).
- CNT_W, 4: width of the per-byte debounce counters; must hold DEB_CNT-1.

Ports:
- zegar  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous reset, active-high.
- raw0..raw7  input  8 each  asynchronous field inputs, byte n feeds In.
- scan_req  input  1  level request from processor: "latch new image".
- scan_ack  output  1  one-cycle pulse: image latched on this edge.
- I0..I7  output  8 each  frozen process-input image, connects to processor I0..I7.
- image_changed  output  1  latched image differs from the previous latched image.
- deb_busy  output  1  OR over bytes of (candidate != debounced); diagnostic only.

Behaviour:
- Reset (synchronous, reset=1 at an edge) clears all of the following:
  - sync1/sync2, cand, deb, cnt, prescaler, I0..I7;
  - scan_ack, image_changed;
  - FSM returns to IDLE.
- Reset overrides every other event, including a scan in progress; no latch occurs on a reset edge.
- Synchroniser: per byte, two flops, raw -> sync1 -> sync2 (2-cycle latency).
- Prescaler: counts 0..PRESC-1 and wraps; tick=1 in the cycle where count==PRESC-1. With PRESC=1, tick is always 1.
- Debounce, per byte n, evaluated on tick edges only:
  - sync2!=cand: cand<=sync2, cnt<=0.
  - Else if cand!=deb and cnt==DEB_CNT-1: deb<=cand, cnt<=0.
  - Else if cand!=deb: cnt<=cnt+1.
  - Else: cnt<=0.
- Debounce timing consequences:
  - A stable change in sync2 reaches deb on the (DEB_CNT+1)-th tick after it is first seen.
  - A glitch shorter than one tick period may be missed entirely.
  - A bounce restarts the count.
- Image FSM:
  - IDLE: if scan_req=1, then I_n<=deb_n for all n, image_changed<=(new image != current I0..I7 as a 64-bit compare), scan_ack<=1, go to ACK.
  - ACK: scan_ack<=0, go to HOLD.
  - HOLD: stay until scan_req=0, then go to IDLE.
- Latency: scan_req high at edge k (in IDLE) -> I0..I7 and scan_ack valid after edge k; scan_ack high for exactly one cycle.
- I0..I7 change only on a latch edge; debounced changes between scans are invisible to the processor.
- scan_req held high continuously produces exactly one latch per high period. Re-arming requires scan_req=0 for at least one edge.
- A deb update and a latch on the same edge: the latch takes the pre-edge deb value; the update is seen at the next scan.
- image_changed holds its value until the next latch.

Optional Feature:
- Macro: INPUT_FORCE_EN.
- Defined:
  - Adds ports force_we (in, 1), force_sel (in, 3), force_mask (in, 8) and force_val (in, 8).
  - force_we=1 at an edge writes mask/val registers for byte force_sel.
  - At latch, byte n = (deb_n & ~mask_n) | (val_n & mask_n).
  - Mask and val registers reset to 0.
- Not defined: those ports and registers do not exist; latch uses deb_n directly.

Test Plan:
- Reset: reset=1 for 2 edges with raw0=FF -> I0..I7=00, scan_ack=0, image_changed=0, deb_busy=0.
- Debounce, PRESC=4, DEB_CNT=3:
  - Stimulus: raw3 00->A5 held stable.
  - Required: deb3=A5 on the 4th tick after sync2=A5.
  - Required: I3 stays 00 until the next scan; scan then gives I3=A5, scan_ack one-cycle pulse, image_changed=1.
- Bounce: raw1 toggles 00/0F every 3 cycles for 40 cycles, then settles at 0F -> deb1 remains 00 during toggling, becomes 0F only after settling plus the debounce time.
- Handshake: scan_req held high 10 cycles -> exactly one scan_ack pulse; a second scan with no input change -> image_changed=0.
- Reset mid-scan: reset asserted on the edge where scan_req rises -> no latch, scan_ack=0, FSM in IDLE; next scan_req works normally.
- INPUT_FORCE_EN build: force byte 5, mask F0, val A0, raw5 debounced 0C -> after scan, I5=AC.
